collider_arbiter: RTL and testbench
===================================

# collider_arbiter

Time-multiplexes the single combinational level collider between NUM_PLAYERS requesters (fireboy, icegirl) once per motion update. Each player module raises a request with its position, and the arbiter grants requests round-robin. It drives the shared collider inputs, waits a fixed settle time, then returns the registered movement bounds with a one-cycle acknowledge. It sits between the player motion modules and the collider, removing the duplicated collider instance per player.

## Interface
- NUM_PLAYERS, 2: number of requesters (2..4)
- SETTLE_CYCLES, 2: cycles the collider inputs are held before the bounds are captured (≥1)
- Clk  in  1  system clock; single clock domain
- Reset  in  1  asynchronous, active-high reset
- req  in  NUM_PLAYERS  level request per player; held with stable position until ack
- pos_x, pos_y  in  NUM_PLAYERS×32  signed integer player positions
- flush  in  1  level-load pulse; clears the cache (see Configuration)
- col_x_pos, col_y_pos  out  32  registered inputs to the shared collider
- col_x_min, col_x_max, col_y_min, col_y_max  in  32  collider results
- ack  out  NUM_PLAYERS  one-hot, one-cycle pulse; result bus valid in that cycle
- res_x_min, res_x_max, res_y_min, res_y_max  out  32  captured bounds
- res_id  out  log2(NUM_PLAYERS)  index of the serviced player
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** if any req bit is set, grant the first set bit searching from last_grant+1 (wrapping modulo NUM_PLAYERS). On the grant:
  - latch pos_x/pos_y[grant] into col_x_pos/col_y_pos
  - set res_id = grant
  - set cnt = SETTLE_CYCLES-1
  - go to WAIT
- **WAIT:** if cnt==0, register the four collider outputs into res_* and go to RESP; otherwise decrement cnt.
- **RESP:** ack[res_id]=1 for exactly this cycle. last_grant ← res_id; go to IDLE.
- A req dropped after grant does not abort the transaction: the ack still pulses, and the requester ignores it.
- A req held high after its ack makes that player eligible again next IDLE. With other requesters pending, round-robin services them first.
- Position changes during WAIT are ignored, because col_* stay latched.
- Reset values:
  - state=IDLE, cnt=0, ack=0, busy=0, res_id=0
  - last_grant=NUM_PLAYERS-1, so player 0 wins the first contention
  - col_x_pos=col_y_pos=0
  - res_x_min=0, res_x_max=639, res_y_min=0, res_y_max=479 (full-screen defaults)
- Reset asserted mid-transaction returns to IDLE immediately with no ack and no partial result.
- Bounds pass through unmodified at full 32-bit signed width; no arithmetic is performed on them.

## Timing
- Let the grant edge be cycle 0, the IDLE cycle in which req is sampled.
- col_* are valid from cycle 1; capture happens at the end of cycle SETTLE_CYCLES.
- ack is high in cycle SETTLE_CYCLES+1, giving a miss latency of SETTLE_CYCLES+1 cycles.
- The next grant is earliest in cycle SETTLE_CYCLES+2, because there is one IDLE cycle between transactions.
- Throughput is one query per SETTLE_CYCLES+2 cycles. With defaults, two players complete in 8 cycles, far inside one frame.
- Simultaneous req from all players: serviced in round-robin order, with no starvation.

## Configuration
- **With COLLIDER_CACHE_EN defined:**
  - Per-player cache of last position, last bounds and a valid bit.
  - In IDLE, if the granted player's pos matches its cache and valid=1, the arbiter skips WAIT. It loads res_* from the cache, goes straight to RESP, and ack arrives in cycle 1.
  - On a miss, the captured bounds and position are written to the cache at the WAIT→RESP transition.
  - flush clears all valid bits. If flush coincides with a hit in IDLE, the hit is treated as a miss.
  - Reset clears all valid bits.
- **Without COLLIDER_CACHE_EN:** no cache storage; flush is ignored; every query takes the full miss latency.

## Structure
- The shared package (collider_pkg) holds:
  - state enum collider_arb_state_t
  - screen-bound constants SCREEN_X_MAX=639, SCREEN_Y_MAX=479
  - bounds struct collider_bounds_t containing x_min, x_max, y_min, y_max
- One sub-module, rr_picker: combinational round-robin priority pick from req and last_grant, producing grant index and a valid flag.
- The collider itself is instantiated at top level and wired to the col_* ports, not inside this block.

## Test plan
- Reset defaults: after Reset deasserts, check ack=0, busy=0 and res bounds 0/639/0/479.
- Single miss: req[0] with pos (100,420), SETTLE_CYCLES=2, collider returning 0/575/415/479 → ack[0] in cycle 3, res_id=0, res = 0/575/415/479, busy high in cycles 1–3.
- Contention: req=2'b11 held continuously → acks alternate 0,1,0,1, one every 4 cycles; player 0 goes first after reset.
- Reset mid-op: assert Reset during WAIT → no ack, state IDLE, res at defaults; a new req afterwards completes normally.
- Dropped req: req[1] deasserted one cycle after grant → ack[1] still pulses, and the next transaction proceeds normally.
- Cache (COLLIDER_CACHE_EN): same pos queried twice → second ack in cycle 1 with identical bounds; after a flush pulse, the same pos takes the full latency.

Source files
------------

// File: rtl/collider_pkg.sv
// collider_pkg: shared types and constants for the collider arbiter.
//   collider_arb_state_t : arbiter FSM states (IDLE, WAIT, RESP)
//   SCREEN_X_MAX/Y_MAX   : full-screen movement limits
//   collider_bounds_t    : the four movement bounds returned by the collider
//   SCREEN_BOUNDS        : full-screen bounds reported before any query completes
`timescale 1ns/1ps
package collider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } collider_arb_state_t;

  localparam logic [31:0] SCREEN_X_MAX = 32'd639;
  localparam logic [31:0] SCREEN_Y_MAX = 32'd479;

  // Bounds are signed in the game's coordinate space but are never operated
  // on here, so they travel as raw 32-bit words.
  typedef struct packed {
    logic [31:0] x_min;
    logic [31:0] x_max;
    logic [31:0] y_min;
    logic [31:0] y_max;
  } collider_bounds_t;

  localparam collider_bounds_t SCREEN_BOUNDS = '{
    x_min: 32'd0,
    x_max: SCREEN_X_MAX,
    y_min: 32'd0,
    y_max: SCREEN_Y_MAX
  };

endpackage

// File: rtl/collider_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick.
//   req         in  NUM_PLAYERS  pending requests
//   last_grant  in  ID_W         most recently serviced player
//   grant       out ID_W         first set req bit after last_grant (wrapping)
//   grant_valid out 1            any request pending
`timescale 1ns/1ps
module rr_picker #(
  parameter int  NUM_PLAYERS = 2,
  localparam int ID_W        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic [NUM_PLAYERS-1:0] req,
  input  logic [ID_W-1:0]        last_grant,
  output logic [ID_W-1:0]        grant,
  output logic                   grant_valid
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest candidate back to the nearest one so the nearest
  // set bit after last_grant is the final (winning) assignment.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NUM_PLAYERS; i >= 1; i--) begin
      idx = ID_W'((int'(last_grant) + i) % NUM_PLAYERS);
      if (req[idx]) begin
        grant = idx;
      end
    end
    grant_valid = |req;
  end

endmodule

// File: rtl/collider_arbiter.sv
// collider_arbiter: time-multiplexes one shared combinational collider among
// NUM_PLAYERS requesters with round-robin arbitration.
//   clk, rst                  clock, asynchronous active-high reset
//   req[NUM_PLAYERS]          level request, position held stable until ack
//   pos_x/pos_y[NUM_PLAYERS]  player positions (32-bit signed)
//   flush                     level-load pulse, invalidates the cache
//   col_x_pos/col_y_pos       registered inputs to the shared collider
//   col_{x,y}_{min,max}       collider results
//   ack[NUM_PLAYERS]          one-hot one-cycle pulse, res_* valid with it
//   res_{x,y}_{min,max}       captured bounds
//   res_id                    serviced player index
//   busy                      FSM not in IDLE
// Optional feature: define COLLIDER_CACHE_EN to add a per-player result cache
// (last position + bounds + valid); a hit skips WAIT and acks one cycle after
// the grant.
`timescale 1ns/1ps
module collider_arbiter
  import collider_pkg::*;
#(
  parameter int  NUM_PLAYERS   = 2,
  parameter int  SETTLE_CYCLES = 2,
  localparam int ID_W          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PLAYERS-1:0]      req,
  input  logic [NUM_PLAYERS-1:0][31:0] pos_x,
  input  logic [NUM_PLAYERS-1:0][31:0] pos_y,
  input  logic                        flush,
  output logic [31:0]                 col_x_pos,
  output logic [31:0]                 col_y_pos,
  input  logic [31:0]                 col_x_min,
  input  logic [31:0]                 col_x_max,
  input  logic [31:0]                 col_y_min,
  input  logic [31:0]                 col_y_max,
  output logic [NUM_PLAYERS-1:0]      ack,
  output logic [31:0]                 res_x_min,
  output logic [31:0]                 res_x_max,
  output logic [31:0]                 res_y_min,
  output logic [31:0]                 res_y_max,
  output logic [ID_W-1:0]             res_id,
  output logic                        busy
);

  localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  collider_arb_state_t      state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ID_W-1:0]          last_grant_q, last_grant_d;
  logic [ID_W-1:0]          res_id_q, res_id_d;
  logic [31:0]              col_x_q, col_x_d;
  logic [31:0]              col_y_q, col_y_d;
  collider_bounds_t         res_q, res_d;
  logic [NUM_PLAYERS-1:0]   ack_q, ack_d;

  logic [ID_W-1:0]          grant;
  logic                     grant_valid;
  collider_bounds_t         col_bounds;

  assign col_bounds = '{x_min: col_x_min, x_max: col_x_max,
                        y_min: col_y_min, y_max: col_y_max};

  rr_picker #(
    .NUM_PLAYERS (NUM_PLAYERS)
  ) u_picker (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

`ifdef COLLIDER_CACHE_EN
  logic [NUM_PLAYERS-1:0] cache_valid_q, cache_valid_d;
  logic [31:0]            cache_x_q [NUM_PLAYERS];
  logic [31:0]            cache_x_d [NUM_PLAYERS];
  logic [31:0]            cache_y_q [NUM_PLAYERS];
  logic [31:0]            cache_y_d [NUM_PLAYERS];
  collider_bounds_t       cache_b_q [NUM_PLAYERS];
  collider_bounds_t       cache_b_d [NUM_PLAYERS];
  logic                   hit;

  // A flush in the same cycle as a lookup forces a miss, since the cached
  // bounds belong to the previous level.
  assign hit = grant_valid && cache_valid_q[grant] && !flush &&
               (cache_x_q[grant] == pos_x[grant]) &&
               (cache_y_q[grant] == pos_y[grant]);
`else
  logic unused_flush;
  assign unused_flush = flush;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    res_id_d     = res_id_q;
    col_x_d      = col_x_q;
    col_y_d      = col_y_q;
    res_d        = res_q;
    ack_d        = '0;
`ifdef COLLIDER_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_x_d     = cache_x_q;
    cache_y_d     = cache_y_q;
    cache_b_d     = cache_b_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          col_x_d  = pos_x[grant];
          col_y_d  = pos_y[grant];
          res_id_d = grant;
          cnt_d    = CNT_LOAD;
          state_d  = WAIT;
`ifdef COLLIDER_CACHE_EN
          if (hit) begin
            res_d        = cache_b_q[grant];
            ack_d[grant] = 1'b1;
            state_d      = RESP;
          end
`endif
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          res_d           = col_bounds;
          ack_d[res_id_q] = 1'b1;
          state_d         = RESP;
`ifdef COLLIDER_CACHE_EN
          cache_valid_d[res_id_q] = 1'b1;
          cache_x_d[res_id_q]     = col_x_q;
          cache_y_d[res_id_q]     = col_y_q;
          cache_b_d[res_id_q]     = col_bounds;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        last_grant_d = res_id_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef COLLIDER_CACHE_EN
    // Flush wins over a same-cycle fill: the fill came from the old level.
    if (flush) begin
      cache_valid_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= ID_W'(NUM_PLAYERS - 1);
      res_id_q     <= '0;
      col_x_q      <= '0;
      col_y_q      <= '0;
      res_q        <= SCREEN_BOUNDS;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      res_id_q     <= res_id_d;
      col_x_q      <= col_x_d;
      col_y_q      <= col_y_d;
      res_q        <= res_d;
      ack_q        <= ack_d;
    end
  end

`ifdef COLLIDER_CACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid_q <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        cache_x_q[i] <= '0;
        cache_y_q[i] <= '0;
        cache_b_q[i] <= SCREEN_BOUNDS;
      end
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_x_q     <= cache_x_d;
      cache_y_q     <= cache_y_d;
      cache_b_q     <= cache_b_d;
    end
  end
`endif

  assign col_x_pos = col_x_q;
  assign col_y_pos = col_y_q;
  assign ack       = ack_q;
  assign res_x_min = res_q.x_min;
  assign res_x_max = res_q.x_max;
  assign res_y_min = res_q.y_min;
  assign res_y_max = res_q.y_max;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_collider_arbiter.sv
`timescale 1ns/1ps
module tb_collider_arbiter;

  localparam int NP = 2;
  localparam int SC = 2;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;
`ifdef COLLIDER_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0]        req;
  logic [NP-1:0][31:0]  pos_x, pos_y;
  logic                 flush;
  logic [31:0]          col_x_pos, col_y_pos;
  logic [31:0]          col_x_min, col_x_max, col_y_min, col_y_max;
  logic [NP-1:0]        ack;
  logic [31:0]          res_x_min, res_x_max, res_y_min, res_y_max;
  logic [IW-1:0]        res_id;
  logic                 busy;

  always #5 clk = ~clk;

  collider_arbiter #(.NUM_PLAYERS(NP), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .req(req), .pos_x(pos_x), .pos_y(pos_y), .flush(flush),
    .col_x_pos(col_x_pos), .col_y_pos(col_y_pos),
    .col_x_min(col_x_min), .col_x_max(col_x_max), .col_y_min(col_y_min), .col_y_max(col_y_max),
    .ack(ack), .res_x_min(res_x_min), .res_x_max(res_x_max), .res_y_min(res_y_min),
    .res_y_max(res_y_max), .res_id(res_id), .busy(busy)
  );

  // Stand-in collider: bounds depend on position and on the current level,
  // so stale cached bounds after a level change would be visible.
  int level = 0;
  function automatic logic [31:0] bnd(input int k, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] off;
    off = 32'(level * 3);
    case (k)
      0:       return x - 32'd100 + off;
      1:       return x + 32'd475 + off;
      2:       return y - 32'd5 + off;
      default: return y + 32'd59 + off;
    endcase
  endfunction
  assign col_x_min = bnd(0, col_x_pos, col_y_pos);
  assign col_x_max = bnd(1, col_x_pos, col_y_pos);
  assign col_y_min = bnd(2, col_x_pos, col_y_pos);
  assign col_y_max = bnd(3, col_x_pos, col_y_pos);

  // Scoreboard entry: who should be acked, with what bounds, and how many
  // cycles after the reference event (phase issue or previous ack).
  typedef struct {
    int          id;
    logic [31:0] b0, b1, b2, b3;
    bit          from_issue;
    int          gap;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int last_ack_cyc = 0;

  // Requester behaviour: hold req until the wanted number of acks arrived.
  logic [NP-1:0] active;
  int            target [NP];
  int            ack_cnt [NP];
  int            ph_cnt [NP];

  always_comb begin
    req = '0;
    for (int i = 0; i < NP; i++) req[i] = active[i] && (ack_cnt[i] < target[i]);
  end

  // Reference model state: round-robin pointer and per-player cache view.
  int          m_last;
  bit          m_valid [NP];
  logic [31:0] m_px [NP];
  logic [31:0] m_py [NP];
  logic [31:0] m_b [NP][4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops one expectation per ack pulse.
  initial begin
    exp_t e;
    for (int i = 0; i < NP; i++) ack_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst && ack !== '0) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = q.pop_front();
          chk("ack_onehot", 32'(ack), 32'(1) << e.id);
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("res_x_min", res_x_min, e.b0);
          chk("res_x_max", res_x_max, e.b1);
          chk("res_y_min", res_y_min, e.b2);
          chk("res_y_max", res_y_max, e.b3);
          chk("busy_at_ack", 32'(busy), 32'd1);
          chk("ack_latency", 32'(cyc - (e.from_issue ? issue_cyc : last_ack_cyc)), 32'(e.gap));
        end
        for (int i = 0; i < NP; i++) if (ack[i]) ack_cnt[i]++;
        last_ack_cyc = cyc;
      end
    end
  end

  task automatic model_reset();
    m_last = NP - 1;
    for (int i = 0; i < NP; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    level++;
    for (int i = 0; i < NP; i++) m_valid[i] = 1'b0;
  endtask

  // One phase: players in 'set' each want ph_cnt[i] services; expected order
  // is plain round-robin over players that still need service.
  task automatic run_phase(input logic [NP-1:0] set, input bit drop_early, input bit wiggle);
    int   pend [NP];
    int   p;
    int   budget;
    bit   first;
    bit   hit;
    exp_t e;
    for (int i = 0; i < NP; i++) pend[i] = set[i] ? ph_cnt[i] : 0;
    first = 1'b1;
    forever begin
      p = -1;
      for (int k = 1; k <= NP; k++) begin
        int idx;
        idx = (m_last + k) % NP;
        if (p < 0 && pend[idx] > 0) p = idx;
      end
      if (p < 0) break;
      hit = CACHE && m_valid[p] && m_px[p] == pos_x[p] && m_py[p] == pos_y[p];
      if (!hit) begin
        m_valid[p] = 1'b1;
        m_px[p] = pos_x[p];
        m_py[p] = pos_y[p];
        for (int k = 0; k < 4; k++) m_b[p][k] = bnd(k, pos_x[p], pos_y[p]);
      end
      e.id = p;
      e.b0 = m_b[p][0]; e.b1 = m_b[p][1]; e.b2 = m_b[p][2]; e.b3 = m_b[p][3];
      e.from_issue = first;
      e.gap = (first ? 0 : 2) + (hit ? 0 : SC);
      q.push_back(e);
      m_last = p;
      pend[p]--;
      first = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < NP; i++) if (set[i]) target[i] = ack_cnt[i] + ph_cnt[i];
    issue_cyc = cyc + 1;
    active = set;
    if (drop_early || wiggle) begin
      @(negedge clk);
      if (drop_early) active = '0;
      if (wiggle) for (int i = 0; i < NP; i++) if (set[i]) pos_x[i] = pos_x[i] + 32'd7;
    end
    budget = 0;
    while ((q.size() != 0 || busy) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 400) begin
      total++;
      $display("FAIL phase_timeout: %0d acks still outstanding, want 0", q.size());
      q.delete();
    end
    active = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] set;
    rst = 1'b1;
    flush = 1'b0;
    active = '0;
    pos_x = '0;
    pos_y = '0;
    for (int i = 0; i < NP; i++) begin target[i] = 0; ph_cnt[i] = 0; end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_x_min", res_x_min, 32'd0);
    chk("rst_res_x_max", res_x_max, 32'd639);
    chk("rst_res_y_min", res_y_min, 32'd0);
    chk("rst_res_y_max", res_y_max, 32'd479);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_col_x", col_x_pos, 32'd0);

    // Single miss at (100,420)
    pos_x[0] = 32'd100; pos_y[0] = 32'd420;
    ph_cnt[0] = 1; ph_cnt[1] = 0;
    run_phase(2'b01, 1'b0, 1'b0);
    chk("single_x_min", res_x_min, 32'd0);
    chk("single_x_max", res_x_max, 32'd575);
    chk("single_y_min", res_y_min, 32'd415);
    chk("single_y_max", res_y_max, 32'd479);

    // Same position again (cache hit when enabled), then after a flush
    run_phase(2'b01, 1'b0, 1'b0);
    do_flush();
    run_phase(2'b01, 1'b0, 1'b0);

    // Contention: both held for three services each
    pos_x[1] = 32'd200; pos_y[1] = 32'd100;
    ph_cnt[0] = 3; ph_cnt[1] = 3;
    run_phase(2'b11, 1'b0, 1'b0);

    // Dropped request, then a normal one
    ph_cnt[1] = 1;
    run_phase(2'b10, 1'b1, 1'b0);
    run_phase(2'b10, 1'b0, 1'b0);

    // Position change while the query is in flight
    ph_cnt[0] = 1;
    run_phase(2'b01, 1'b0, 1'b1);

    // Reset in the middle of a transaction (flush first so it is a miss)
    do_flush();
    @(negedge clk);
    target[1] = ack_cnt[1] + 1;
    active = 2'b10;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_res_x_max", res_x_max, 32'd639);
    chk("midrst_res_y_max", res_y_max, 32'd479);
    chk("midrst_res_x_min", res_x_min, 32'd0);
    @(negedge clk);
    active = '0;
    rst = 1'b0;
    model_reset();
    ph_cnt[0] = 1; ph_cnt[1] = 1;
    run_phase(2'b11, 1'b0, 1'b0);

    // Randomized phases
    for (int n = 0; n < 30; n++) begin
      int sel;
      if ($urandom_range(0, 4) == 0) do_flush();
      for (int i = 0; i < NP; i++) begin
        sel = $urandom_range(0, 2);
        pos_x[i] = (sel == 0) ? 32'd100 : (sel == 1) ? 32'd200 : 32'd300 + 32'(i);
        pos_y[i] = (sel == 0) ? 32'd420 : (sel == 1) ? 32'd100 : 32'd300;
        ph_cnt[i] = $urandom_range(1, 3);
      end
      set = NP'($urandom_range(1, (1 << NP) - 1));
      if ($countones(set) == 1) begin
        ph_cnt[0] = 1; ph_cnt[1] = 1;
        run_phase(set, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else begin
        run_phase(set, 1'b0, 1'b0);
      end
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
